// File: rtl/robot_pkg.sv
// -----------------------------------------------------------------------------
// robot_pkg
// Shared definitions for the differential-drive robot controller:
//   - 3-bit move command encodings (CMD_*)
//   - 2-bit per-wheel drive codes (WHL_*)
//   - power sequencer state type
//   - decode_move(): command -> {left, right} wheel codes
// -----------------------------------------------------------------------------
package robot_pkg;

  // Move commands as presented on move_i.
  localparam logic [2:0] CMD_STAY     = 3'b000;
  localparam logic [2:0] CMD_STAY_ALT = 3'b100;
  localparam logic [2:0] CMD_FWD      = 3'b111;
  localparam logic [2:0] CMD_BWD      = 3'b011;
  localparam logic [2:0] CMD_LEFT     = 3'b101;
  localparam logic [2:0] CMD_RIGHT    = 3'b110;

  // Wheel drive codes. 2'b11 is reserved and never driven.
  localparam logic [1:0] WHL_STOP = 2'b00;
  localparam logic [1:0] WHL_FWD  = 2'b01;
  localparam logic [1:0] WHL_REV  = 2'b10;

  typedef enum logic [1:0] {
    PWR_OFF    = 2'd0,
    PWR_SPINUP = 2'd1,
    PWR_ON     = 2'd2
  } pwr_state_t;

  typedef struct packed {
    logic [1:0] left;
    logic [1:0] right;
  } wheel_pair_t;

  // Any command not listed maps to stop, so the reserved wheel code and
  // unlisted wheel combinations can never be produced.
  function automatic wheel_pair_t decode_move(input logic [2:0] cmd);
    wheel_pair_t w;
    w = '{left: WHL_STOP, right: WHL_STOP};
    case (cmd)
      CMD_FWD:               w = '{left: WHL_FWD, right: WHL_FWD};
      CMD_BWD:               w = '{left: WHL_REV, right: WHL_REV};
      CMD_LEFT:              w = '{left: WHL_REV, right: WHL_FWD};
      CMD_RIGHT:             w = '{left: WHL_FWD, right: WHL_REV};
      CMD_STAY, CMD_STAY_ALT: w = '{left: WHL_STOP, right: WHL_STOP};
      default:               w = '{left: WHL_STOP, right: WHL_STOP};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/robot_power_seq.sv
// -----------------------------------------------------------------------------
// robot_power_seq
// Motor power sequencer: OFF -> SPINUP (STARTUP_CYCLES cycles) -> ON.
// Dropping motor_on_i returns to OFF from any state on the same edge.
// Ports:
//   clk_i        in   system clock, rising edge
//   rstn_i       in   asynchronous active-low reset
//   motor_on_i   in   level-sensitive power request
//   motor_status out  registered, 1 only in ON
//   run_en       out  registered, 1 only in ON (gates command execution)
// -----------------------------------------------------------------------------
module robot_power_seq
  import robot_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic motor_on_i,
  output logic motor_status,
  output logic run_en
);

  localparam logic [3:0] CNT_LAST = 4'(STARTUP_CYCLES - 1);

  pwr_state_t state;
  logic [3:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register here has an async reset value so no state is left undefined.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= PWR_OFF;
      cnt          <= '0;
      motor_status <= 1'b0;
      run_en       <= 1'b0;
    end else if (!motor_on_i) begin
      // Power request wins over everything else on this edge.
      state        <= PWR_OFF;
      cnt          <= '0;
      motor_status <= 1'b0;
      run_en       <= 1'b0;
    end else begin
      case (state)
        PWR_OFF: begin
          state <= PWR_SPINUP;
          cnt   <= '0;
        end
        PWR_SPINUP: begin
          if (cnt == CNT_LAST) begin
            state        <= PWR_ON;
            motor_status <= 1'b1;
            run_en       <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        PWR_ON: begin
          motor_status <= 1'b1;
          run_en       <= 1'b1;
        end
        default: begin
          state        <= PWR_OFF;
          cnt          <= '0;
          motor_status <= 1'b0;
          run_en       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/robot_ctrl.sv
// -----------------------------------------------------------------------------
// robot_ctrl
// Drive controller for a two-wheel differential robot. Sequences motor power,
// decodes 3-bit move commands into registered per-wheel codes and mirrors the
// forward obstacle sensor.
// Configuration macro: ROBOT_OBSTACLE_STOP_EN
//   defined   - a forward command sampled with tracker_fwrd_i=1 becomes stay
//   undefined - tracker is status-only
// Ports:
//   clk_i            in   system clock, rising edge
//   rstn_i           in   asynchronous active-low reset
//   motor_on_i       in   motor power request (level)
//   motor_status_o   out  1 = motors powered and accepting commands
//   move_i[2:0]      in   move command, sampled every cycle
//   tracker_fwrd_i   in   forward obstacle sensor
//   tracker_status_o out  tracker_fwrd_i delayed one cycle
//   left_motor_o     out  left wheel code (00 stop, 01 fwd, 10 rev)
//   right_motor_o    out  right wheel code
// -----------------------------------------------------------------------------
module robot_ctrl
  import robot_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       motor_on_i,
  output logic       motor_status_o,
  input  logic [2:0] move_i,
  input  logic       tracker_fwrd_i,
  output logic       tracker_status_o,
  output logic [1:0] left_motor_o,
  output logic [1:0] right_motor_o
);

  logic        run_en;
  wheel_pair_t next_wheels;

  robot_power_seq #(
    .STARTUP_CYCLES(STARTUP_CYCLES)
  ) u_power_seq (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .motor_on_i  (motor_on_i),
    .motor_status(motor_status_o),
    .run_en      (run_en)
  );

  // NOTE: the decode result gets its value on the first line so no path
  // through this block leaves it unassigned (which would infer a latch).
  always_comb begin
    next_wheels = decode_move(move_i);
`ifdef ROBOT_OBSTACLE_STOP_EN
    if (move_i == CMD_FWD && tracker_fwrd_i) begin
      next_wheels = '{left: WHL_STOP, right: WHL_STOP};
    end
`endif
    // Run enable reflects the state at this edge; motor_on_i is checked too
    // so a drop clears the wheels on the same edge the FSM leaves ON.
    if (!(run_en && motor_on_i)) begin
      next_wheels = '{left: WHL_STOP, right: WHL_STOP};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      left_motor_o     <= WHL_STOP;
      right_motor_o    <= WHL_STOP;
      tracker_status_o <= 1'b0;
    end else begin
      left_motor_o     <= next_wheels.left;
      right_motor_o    <= next_wheels.right;
      tracker_status_o <= tracker_fwrd_i;
    end
  end

endmodule

// File: tb/tb_robot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_robot_ctrl
// Self-checking bench for robot_ctrl. The reference model tracks how many
// consecutive edges have sampled motor_on_i=1 and derives status, wheel codes
// and tracker echo from the behavioural rules directly.
// -----------------------------------------------------------------------------
module tb_robot_ctrl;

  localparam int unsigned STARTUP = 1;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       motor_on_i;
  logic       motor_status_o;
  logic [2:0] move_i;
  logic       tracker_fwrd_i;
  logic       tracker_status_o;
  logic [1:0] left_motor_o;
  logic [1:0] right_motor_o;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int       on_run;
  logic     exp_status;
  logic [3:0] exp_wheels;
  logic     exp_trk;

  robot_ctrl #(.STARTUP_CYCLES(STARTUP)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .motor_on_i      (motor_on_i),
    .motor_status_o  (motor_status_o),
    .move_i          (move_i),
    .tracker_fwrd_i  (tracker_fwrd_i),
    .tracker_status_o(tracker_status_o),
    .left_motor_o    (left_motor_o),
    .right_motor_o   (right_motor_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] ref_decode(input logic [2:0] cmd, input logic trk);
    logic [3:0] r;
    case (cmd)
      3'b111:  r = 4'b0101;
      3'b011:  r = 4'b1010;
      3'b101:  r = 4'b1001;
      3'b110:  r = 4'b0110;
      default: r = 4'b0000;
    endcase
`ifdef ROBOT_OBSTACLE_STOP_EN
    if (cmd == 3'b111 && trk) r = 4'b0000;
`else
    if (trk && 1'b0) r = 4'b0000;
`endif
    return r;
  endfunction

  function automatic logic [5:0] observed();
    return {motor_status_o, left_motor_o, right_motor_o, tracker_status_o};
  endfunction

  function automatic logic [5:0] expected();
    return {exp_status, exp_wheels, exp_trk};
  endfunction

  function automatic void model_reset();
    on_run     = 0;
    exp_status = 1'b0;
    exp_wheels = 4'b0000;
    exp_trk    = 1'b0;
  endfunction

  // Drive one cycle of inputs, advance one rising edge, update the model,
  // and leave the bench 1 time unit after the edge for sampling.
  task automatic step(input logic on, input logic [2:0] mv, input logic trk);
    motor_on_i     = on;
    move_i         = mv;
    tracker_fwrd_i = trk;
    @(posedge clk_i);
    // Command runs only if motors were already on and power is still requested.
    exp_wheels = (exp_status && on) ? ref_decode(mv, trk) : 4'b0000;
    on_run     = on ? on_run + 1 : 0;
    exp_status = (on_run >= int'(STARTUP) + 1);
    exp_trk    = trk;
    #1;
  endtask

  task automatic power_up();
    for (int i = 0; i < int'(STARTUP) + 1; i++) step(1'b1, 3'b000, 1'b0);
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    motor_on_i = 1'b0; move_i = 3'b000; tracker_fwrd_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if (observed() !== 6'b0) begin
      bad++; $display("FAIL reset: got %b want %b", observed(), 6'b0);
    end
    rstn_i = 1'b1;
    step(1'b0, 3'b111, 1'b0);
    total++;
    if (observed() !== expected()) begin
      bad++; $display("FAIL reset_idle: got %b want %b", observed(), expected());
    end
  endtask

  task automatic test_powerup();
    step(1'b1, 3'b111, 1'b0);
    total++;
    if (motor_status_o !== 1'b0 || observed() !== expected()) begin
      bad++; $display("FAIL powerup_edge1: got %b want %b", observed(), expected());
    end
    step(1'b1, 3'b111, 1'b0);
    total++;
    if (motor_status_o !== 1'b1 || observed() !== expected()) begin
      bad++; $display("FAIL powerup_edge2: got %b want %b", observed(), expected());
    end
  endtask

  task automatic test_moves();
    logic [2:0] cmds [9] = '{3'b111, 3'b000, 3'b011, 3'b000, 3'b101, 3'b110,
                             3'b010, 3'b001, 3'b100};
    for (int i = 0; i < 9; i++) begin
      step(1'b1, cmds[i], 1'b0);
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL move_%b: got %b want %b", cmds[i], observed(), expected());
      end
    end
    // A held command repeats for every cycle it is sampled.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b011, 1'b0);
      total++;
      if (left_motor_o !== 2'b10 || right_motor_o !== 2'b10) begin
        bad++; $display("FAIL move_held: got %b%b want 1010", left_motor_o, right_motor_o);
      end
    end
  endtask

  task automatic test_power_drop();
    step(1'b1, 3'b111, 1'b0);
    step(1'b0, 3'b111, 1'b0);
    total++;
    if (observed() !== expected() || {motor_status_o, left_motor_o, right_motor_o} !== 5'b0) begin
      bad++; $display("FAIL power_drop: got %b want %b", observed(), expected());
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b101, 1'b0);
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL power_off_ignore: got %b want %b", observed(), expected());
      end
    end
  endtask

  task automatic test_tracker();
    power_up();
    step(1'b1, 3'b000, 1'b1);
    step(1'b1, 3'b111, 1'b1);
    total++;
    if (tracker_status_o !== 1'b1 || observed() !== expected()) begin
      bad++; $display("FAIL tracker_fwd: got %b want %b", observed(), expected());
    end
    step(1'b1, 3'b011, 1'b0);
    total++;
    if (tracker_status_o !== 1'b0 || observed() !== expected()) begin
      bad++; $display("FAIL tracker_fall: got %b want %b", observed(), expected());
    end
    step(1'b1, 3'b011, 1'b1);
    total++;
    if (observed() !== expected()) begin
      bad++; $display("FAIL tracker_bwd: got %b want %b", observed(), expected());
    end
  endtask

  task automatic test_async_reset();
    power_up();
    step(1'b1, 3'b111, 1'b0);
    #2 rstn_i = 1'b0;
    #1;
    model_reset();
    total++;
    if (observed() !== 6'b0) begin
      bad++; $display("FAIL async_reset: got %b want %b", observed(), 6'b0);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    step(1'b1, 3'b111, 1'b0);
    total++;
    if (motor_status_o !== 1'b0 || observed() !== expected()) begin
      bad++; $display("FAIL respin_edge1: got %b want %b", observed(), expected());
    end
    step(1'b1, 3'b111, 1'b0);
    total++;
    if (motor_status_o !== 1'b1 || observed() !== expected()) begin
      bad++; $display("FAIL respin_edge2: got %b want %b", observed(), expected());
    end
  endtask

  task automatic test_random();
    logic on;
    for (int i = 0; i < 400; i++) begin
      on = ($urandom_range(0, 9) != 0);
      step(on, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL random_%0d: got %b want %b", i, observed(), expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_moves();
    test_power_drop();
    test_tracker();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
